post_run_ctrl: RTL and testbench
================================

# post_run_ctrl

Execution sequencer for the Post machine core (`Post_sys_4Tiny`). It sits between the raw user pins (start button, step switch, mode switch) and the core's `RUN`/`MODE` inputs. It synchronizes the pins, runs a program-load / run / single-step state machine, and detects halt from the core's `STATE` nibble. A cycle counter and watchdog timeout report status back to the top level.

## Interface
Parameters:
- `HALT_CODE`, default 4'hF: `CORE_STATE` value that means the program has halted.
- `TIMEOUT_CYC`, default 16'd60000: run-cycle limit before fault. At 1525.879 Hz this is about 39 s.

Ports:
- `CLK` in 1: single system clock.
- `NRST` in 1: reset, synchronous, active-low.
- `START_REQ` in 1: asynchronous start/step button, level.
- `STEP_MODE` in 1: asynchronous; 1 = single-step, 0 = free run.
- `MODE_REQ` in 1: asynchronous; 1 = program-load (SPI) mode.
- `CORE_STATE` in 4: core state nibble, synchronous to `CLK`.
- `CORE_RUN` out 1: drives core `RUN`.
- `CORE_MODE` out 1: drives core `MODE`.
- `BUSY` out 1: high while in RUN or STEP.
- `DONE` out 1: halt reached.
- `TIMEOUT` out 1: watchdog fault.
- `CYC_CNT` out 16: run cycles of the last or current run.

## Operation
- Inputs `START_REQ`, `STEP_MODE` and `MODE_REQ` each pass through a 2-FF synchronizer. `START_REQ` also gets a registered rising-edge detect, giving `start_p`, a 1-cycle pulse.
- FSM states are IDLE, PROG, RUN, STEP, DONE, FAULT.
- IDLE:
  - mode_s=1 → PROG.
  - Otherwise `start_p` with step_s=0 → RUN.
  - Otherwise `start_p` with step_s=1 → STEP, capturing `CORE_STATE` into `st_prev`.
- PROG: `CORE_MODE`=1 and `start_p` is ignored. mode_s=0 → IDLE.
- RUN: `CORE_RUN`=1.
  - `CORE_STATE`==`HALT_CODE` → DONE.
  - Else `CYC_CNT`==`TIMEOUT_CYC`-1 at the increment → FAULT.
- STEP: `CORE_RUN`=1.
  - `CORE_STATE`==`HALT_CODE` → DONE.
  - Else `CORE_STATE`≠`st_prev` → IDLE.
  - Else timeout → FAULT.
- DONE and FAULT hold their flag.
  - mode_s=1 → PROG.
  - `start_p` → RUN or STEP, chosen by step_s, exactly as from IDLE.
- `CYC_CNT` is cleared on entry to RUN or STEP and increments each cycle `CORE_RUN`=1. It saturates at 16'hFFFF and holds its value outside RUN/STEP.
- `DONE` is set on entry to DONE. `TIMEOUT` is set on entry to FAULT. Both clear on leaving the state.
- Mode changes during RUN/STEP are ignored until DONE, FAULT or IDLE.
- Halt and timeout in the same cycle → DONE wins and `TIMEOUT` stays 0.
- Halt code already present at `start_p` → RUN/STEP is entered, and DONE follows on the next edge with `CYC_CNT`=1.

## Timing
- Every output is a register; there are no combinational paths from inputs to outputs.
- Reset (`NRST`=0 at a rising edge): FSM=IDLE, synchronizers=0, and all outputs 0 (`CORE_RUN`, `CORE_MODE`, `BUSY`, `DONE`, `TIMEOUT`, `CYC_CNT`=0). This applies mid-run too: `CORE_RUN` drops after that edge.
- `START_REQ` high, first sampled at edge 0 → `start_p` after edge 2 → `CORE_RUN`=1 and `BUSY`=1 after edge 3.
- `MODE_REQ` high sampled at edge 0 in IDLE → `CORE_MODE`=1 after edge 3.
- `CORE_STATE` is used unsynchronized. Halt code sampled at edge k → `CORE_RUN`=0, `BUSY`=0, `DONE`=1 after edge k.
- Timeout: the exit to FAULT happens on the edge where `CYC_CNT` reaches `TIMEOUT_CYC`. `CORE_RUN` was high for exactly `TIMEOUT_CYC` cycles.

## Structure
- Package `post_ctrl_pkg`:
  - FSM state enum: 3 bits, IDLE=0, PROG=1, RUN=2, STEP=3, DONE=4, FAULT=5.
  - Default `HALT_CODE` constant.
  - `CYC_W`=16.
- Sub-module `post_sync_edge`: 2-FF synchronizer plus optional registered rising-edge pulse, with the same `CLK`/`NRST`.
  - Instantiated 3 times.
  - The edge output is used only for `START_REQ`.

## Test plan
- Reset: hold `NRST`=0 for 2 edges with every input at 1 → all outputs 0. Release with `START_REQ` already high → no run starts, because there is no rising edge.
- Free run: step_s=0 and `CORE_STATE`=4'h2. Raise `START_REQ` before edge 0 → `CORE_RUN`=1 after edge 3. Drive 4'hF so it is sampled at edge 23 → `CORE_RUN`=0, `DONE`=1, `CYC_CNT`=20.
- Watchdog: `TIMEOUT_CYC`=100, halt never reached → `TIMEOUT`=1, `CORE_RUN`=0, `CYC_CNT`=100, `DONE`=0. The next `START_REQ` edge clears `TIMEOUT` and restarts with `CYC_CNT` counting from 0.
- Single step: `STEP_MODE`=1 and `CORE_STATE`=4'h2, then a start edge. Change `CORE_STATE` to 4'h3 four cycles into the step → back to IDLE after that edge, `CYC_CNT`=5, `DONE`=0. A step that reaches 4'hF → `DONE`=1.
- Program mode: `MODE_REQ`=1 in IDLE → `CORE_MODE`=1 after edge 3. Ten start edges → `CORE_RUN` stays 0. `MODE_REQ`=0 → `CORE_MODE`=0 after 3 edges, then a start edge runs normally.
- Corners:
  - Halt and the final timeout cycle on the same edge → `DONE`=1, `TIMEOUT`=0.
  - `NRST`=0 mid-RUN → all outputs 0 after that edge.
  - `MODE_REQ` toggled during RUN → `CORE_MODE` unchanged until DONE.

Source files
------------

// File: rtl/post_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : post_ctrl_pkg
// Brief    : Shared types and constants for the Post core execution sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package post_ctrl_pkg;

    localparam int CYC_W = 16;

    localparam logic [3:0] c_halt_code = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PROG  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/post_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : post_sync_edge
// Brief    : 2-FF synchronizer with an optional registered rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module post_sync_edge #(
    parameter bit EDGE_EN = 1'b0
) (
    input  logic CLK,
    input  logic NRST,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    // Level comes from the third stage so it lines up with the edge pulse.
    assign o_level = r_sync_d;

    generate
        if (EDGE_EN) begin : g_edge
            logic [2:0] r_fill;
            logic       r_rise;

            // r_fill blocks a false edge while the chain still holds reset zeros.
            always_ff @(posedge CLK) begin
                if (!NRST) begin
                    r_fill <= 3'b000;
                    r_rise <= 1'b0;
                end else begin
                    r_fill <= {r_fill[1:0], 1'b1};
                    r_rise <= r_sync & ~r_sync_d & r_fill[2];
                end
            end

            assign o_rise = r_rise;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/post_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : post_run_ctrl
// Brief    : Load/run/single-step sequencer with halt detect and watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module post_run_ctrl
    import post_ctrl_pkg::*;
#(
    parameter logic [3:0]       HALT_CODE   = c_halt_code,
    parameter logic [CYC_W-1:0] TIMEOUT_CYC = 16'd60000
) (
    input  logic             CLK,
    input  logic             NRST,
    input  logic             START_REQ,
    input  logic             STEP_MODE,
    input  logic             MODE_REQ,
    input  logic [3:0]       CORE_STATE,
    output logic             CORE_RUN,
    output logic             CORE_MODE,
    output logic             BUSY,
    output logic             DONE,
    output logic             TIMEOUT,
    output logic [CYC_W-1:0] CYC_CNT
);

    localparam logic [CYC_W:0] c_one_ext = {{CYC_W{1'b0}}, 1'b1};

    logic w_start_p;
    logic w_start_s_unused;
    logic w_step_s;
    logic w_step_rise_unused;
    logic w_mode_s;
    logic w_mode_rise_unused;

    post_sync_edge #(.EDGE_EN(1'b1)) u_sync_start (
        .CLK     (CLK),
        .NRST    (NRST),
        .i_async (START_REQ),
        .o_level (w_start_s_unused),
        .o_rise  (w_start_p)
    );

    post_sync_edge #(.EDGE_EN(1'b0)) u_sync_step (
        .CLK     (CLK),
        .NRST    (NRST),
        .i_async (STEP_MODE),
        .o_level (w_step_s),
        .o_rise  (w_step_rise_unused)
    );

    post_sync_edge #(.EDGE_EN(1'b0)) u_sync_mode (
        .CLK     (CLK),
        .NRST    (NRST),
        .i_async (MODE_REQ),
        .o_level (w_mode_s),
        .o_rise  (w_mode_rise_unused)
    );

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           w_launch_st;
    logic [3:0]       r_st_prev;
    logic [CYC_W:0]   w_cnt_p1;
    logic [CYC_W-1:0] w_cnt_inc;
    logic             w_halt;
    logic             w_to_hit;
    logic             w_active;
    logic             w_nxt_active;

    assign w_halt       = (CORE_STATE == HALT_CODE);
    assign w_cnt_p1     = {1'b0, r_cyc_cnt_q()} + c_one_ext;
    assign w_cnt_inc    = w_cnt_p1[CYC_W] ? CYC_CNT : w_cnt_p1[CYC_W-1:0];
    assign w_to_hit     = (w_cnt_p1 == {1'b0, TIMEOUT_CYC});
    assign w_active     = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_nxt_active = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_STEP);
    assign w_launch_st  = w_step_s ? ST_STEP : ST_RUN;

    function automatic logic [CYC_W-1:0] r_cyc_cnt_q();
        return CYC_CNT;
    endfunction

    // Halt outranks both the step-exit and the watchdog.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (w_mode_s)
                    w_state_nxt = ST_PROG;
                else if (w_start_p)
                    w_state_nxt = w_launch_st;
            end
            ST_PROG: begin
                if (!w_mode_s)
                    w_state_nxt = ST_IDLE;
            end
            ST_RUN, ST_STEP: begin
                if (w_halt)
                    w_state_nxt = ST_DONE;
                else if ((r_state == ST_STEP) && (CORE_STATE != r_st_prev))
                    w_state_nxt = ST_IDLE;
                else if (w_to_hit)
                    w_state_nxt = ST_FAULT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_state   <= ST_IDLE;
            r_st_prev <= 4'h0;
            CORE_RUN  <= 1'b0;
            CORE_MODE <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            TIMEOUT   <= 1'b0;
            CYC_CNT   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            CORE_RUN  <= w_nxt_active;
            BUSY      <= w_nxt_active;
            CORE_MODE <= (w_state_nxt == ST_PROG);
            DONE      <= (w_state_nxt == ST_DONE);
            TIMEOUT   <= (w_state_nxt == ST_FAULT);
            if (w_active)
                CYC_CNT <= w_cnt_inc;
            else if (w_nxt_active)
                CYC_CNT <= '0;
            if (!w_active && (w_state_nxt == ST_STEP))
                r_st_prev <= CORE_STATE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_post_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_post_run_ctrl
// Brief    : Randomized self-checking bench for post_run_ctrl with a
//            behavioural reference model and directed corner checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_post_run_ctrl;

    localparam int         TO   = 100;
    localparam logic [3:0] HALT = 4'hF;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start_req;
    logic        step_mode;
    logic        mode_req;
    logic [3:0]  core_state;
    logic        core_run;
    logic        core_mode;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cyc_cnt;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    post_run_ctrl #(
        .HALT_CODE   (HALT),
        .TIMEOUT_CYC (16'(TO))
    ) dut (
        .CLK        (clk),
        .NRST       (nrst),
        .START_REQ  (start_req),
        .STEP_MODE  (step_mode),
        .MODE_REQ   (mode_req),
        .CORE_STATE (core_state),
        .CORE_RUN   (core_run),
        .CORE_MODE  (core_mode),
        .BUSY       (busy),
        .DONE       (done),
        .TIMEOUT    (timeout),
        .CYC_CNT    (cyc_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: pin histories since reset plus the run rules.
    bit       s_h[$];
    bit       m_h[$];
    bit       t_h[$];
    int       mk;
    bit       sp, ms, ts;
    bit       m_act, m_step, m_prog, m_done, m_fault;
    logic [3:0] m_prev;
    int       m_cnt;

    initial begin
        m_act = 0; m_step = 0; m_prog = 0; m_done = 0; m_fault = 0;
        m_prev = 4'h0; m_cnt = 0;
    end

    always @(posedge clk) begin
        if (!nrst) begin
            s_h.delete(); m_h.delete(); t_h.delete();
            m_act = 0; m_step = 0; m_prog = 0; m_done = 0; m_fault = 0;
            m_prev = 4'h0; m_cnt = 0;
        end else begin
            s_h.push_back(start_req);
            m_h.push_back(mode_req);
            t_h.push_back(step_mode);
            mk = s_h.size() - 1;
            sp = (mk >= 4) && s_h[mk-3] && !s_h[mk-4];
            ms = (mk >= 3) && m_h[mk-3];
            ts = (mk >= 3) && t_h[mk-3];
            if (m_act) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (core_state == HALT) begin
                    m_act = 0; m_done = 1;
                end else if (m_step && core_state != m_prev) begin
                    m_act = 0;
                end else if (m_cnt == TO) begin
                    m_act = 0; m_fault = 1;
                end
            end else if (m_prog) begin
                if (!ms) m_prog = 0;
            end else if (ms) begin
                m_prog = 1; m_done = 0; m_fault = 0;
            end else if (sp) begin
                m_act = 1; m_step = ts; m_prev = core_state; m_cnt = 0;
                m_done = 0; m_fault = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en)
            check("model", {11'd0, core_run, core_mode, busy, done, timeout, cyc_cnt},
                  {11'd0, m_act, m_prog, m_act, m_done, m_fault, 16'(m_cnt)});
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_run(input string name, input logic val, input int limit);
        bit found = 0;
        for (int i = 0; i < limit; i++) begin
            if (core_run === val) begin
                found = 1;
                break;
            end
            tick();
        end
        check(name, {31'd0, found}, 32'd1);
    endtask

    initial begin
        nrst = 1'b0; start_req = 1'b1; step_mode = 1'b1; mode_req = 1'b1; core_state = 4'hF;

        // Reset with every input high
        tick();
        cmp_en = 1'b1;
        tick();
        check("reset_outputs", {11'd0, core_run, core_mode, busy, done, timeout, cyc_cnt}, 32'd0);

        nrst = 1'b1; mode_req = 1'b0; step_mode = 1'b0; core_state = 4'h2;
        ticks(8);
        check("no_start_after_reset", {31'd0, core_run}, 32'd0);

        // Free run: halt sampled 20 edges after entry
        start_req = 1'b0;
        ticks(4);
        start_req = 1'b1;
        ticks(3);
        check("run_before_edge3", {30'd0, core_run, busy}, 32'd0);
        tick();
        check("run_at_edge3", {30'd0, core_run, busy}, 32'd3);
        ticks(19);
        core_state = HALT;
        tick();
        check("free_run_done", {14'd0, core_run, done, cyc_cnt}, {14'd0, 1'b0, 1'b1, 16'd20});
        start_req = 1'b0; core_state = 4'h2;
        ticks(4);

        // Watchdog
        start_req = 1'b1;
        wait_run("wd_start", 1'b1, 10);
        wait_run("wd_expire", 1'b0, TO + 10);
        check("wd_fault", {13'd0, timeout, core_run, done, cyc_cnt}, {13'd0, 3'b100, 16'd100});
        start_req = 1'b0;
        ticks(4);
        start_req = 1'b1;
        wait_run("wd_restart", 1'b1, 10);
        check("wd_restart_clear", {15'd0, timeout, cyc_cnt}, 32'd0);
        tick();
        check("wd_restart_count", {16'd0, cyc_cnt}, 32'd1);
        core_state = HALT;
        tick();
        start_req = 1'b0; core_state = 4'h2;
        ticks(4);

        // Single step
        step_mode = 1'b1;
        ticks(4);
        start_req = 1'b1;
        wait_run("step_start", 1'b1, 10);
        start_req = 1'b0;
        ticks(4);
        core_state = 4'h3;
        tick();
        check("step_exit", {14'd0, core_run, done, cyc_cnt}, {14'd0, 2'b00, 16'd5});
        ticks(3);
        start_req = 1'b1;
        wait_run("step2_start", 1'b1, 10);
        start_req = 1'b0;
        ticks(2);
        core_state = HALT;
        tick();
        check("step_halt", {14'd0, core_run, done, cyc_cnt}, {14'd0, 2'b01, 16'd3});

        // Halt already present at start
        step_mode = 1'b0;
        ticks(4);
        start_req = 1'b1;
        wait_run("halt_at_start", 1'b1, 10);
        start_req = 1'b0;
        tick();
        check("halt_at_start_done", {14'd0, core_run, done, cyc_cnt}, {14'd0, 2'b01, 16'd1});
        core_state = 4'h2;
        ticks(3);

        // Program mode
        mode_req = 1'b1;
        ticks(3);
        check("prog_before_edge3", {31'd0, core_mode}, 32'd0);
        tick();
        check("prog_at_edge3", {31'd0, core_mode}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            start_req = 1'b1; ticks(3);
            start_req = 1'b0; ticks(3);
        end
        check("prog_no_run", {30'd0, core_run, core_mode}, 32'd1);
        mode_req = 1'b0;
        ticks(4);
        check("prog_exit", {31'd0, core_mode}, 32'd0);
        start_req = 1'b1;
        wait_run("post_prog_run", 1'b1, 10);
        start_req = 1'b0;
        core_state = HALT;
        tick();
        core_state = 4'h2;
        ticks(3);

        // Halt on the final watchdog cycle
        start_req = 1'b1;
        wait_run("race_start", 1'b1, 10);
        start_req = 1'b0;
        ticks(TO - 1);
        core_state = HALT;
        tick();
        check("halt_vs_timeout", {14'd0, done, timeout, cyc_cnt}, {14'd0, 2'b10, 16'd100});
        core_state = 4'h2;
        ticks(3);

        // Mode request toggling during a run
        start_req = 1'b1;
        wait_run("mode_tog_start", 1'b1, 10);
        start_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mode_req = ~mode_req;
            ticks(2);
        end
        ticks(4);
        check("mode_ignored_in_run", {30'd0, core_run, core_mode}, 32'd2);
        core_state = HALT;
        tick();
        check("mode_after_halt", {30'd0, done, core_mode}, 32'd2);
        tick();
        check("mode_enter_prog", {30'd0, done, core_mode}, 32'd1);
        mode_req = 1'b0; core_state = 4'h2;
        ticks(5);

        // Reset in the middle of a run
        start_req = 1'b1;
        wait_run("midrst_start", 1'b1, 10);
        start_req = 1'b0;
        ticks(5);
        nrst = 1'b0;
        tick();
        check("midrun_reset", {11'd0, core_run, core_mode, busy, done, timeout, cyc_cnt}, 32'd0);
        nrst = 1'b1;
        ticks(4);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0)  start_req = ~start_req;
            if ($urandom_range(39) == 0) step_mode = ~step_mode;
            if ($urandom_range(59) == 0) mode_req  = ~mode_req;
            if ($urandom_range(47) == 0)
                core_state = ($urandom_range(3) == 0) ? HALT : 4'($urandom_range(14));
            nrst = ($urandom_range(499) != 0);
            tick();
        end
        nrst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
